// File: rtl/ps2_pkg.sv
// Shared definitions for the buffered PS/2 receiver: FSM encoding, parity modes
// and status-bit positions reported alongside each received byte.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_PUSH
    } rx_state_e;

    localparam int PARITY_ODD  = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_NONE = 2;

    localparam int ERR_PARITY = 0;
    localparam int ERR_STOP   = 1;

    localparam int ENTRY_W = 10;

endpackage

// File: rtl/ps2_byte_fifo.sv
// Show-ahead FIFO holding {status, byte} entries; reports a drop when a push
// arrives while full without a simultaneous pop.
module ps2_byte_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             empty, full, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign pop   = rd_en_i && !empty;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign push  = wr_en_i && (!full || pop);
    assign drop_o = wr_en_i && full && !pop;

    assign rd_valid_o = !empty;
    assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_buffered.sv
// PS/2 device-to-host receiver: synchronises and debounces the bus, decodes
// 11-bit (or 10-bit, no parity) frames and queues bytes with their status.
module ps2_rx_buffered
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_LEN     = 4,
    parameter int PARITY_MODE    = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    input  logic       RX_ENABLE,
    input  logic       RD_EN,
    output logic       RD_VALID,
    output logic [7:0] RD_DATA,
    output logic [1:0] RD_ERR,
    output logic       OVERFLOW,
    input  logic       CLR_OVERFLOW,
    output logic       BUSY
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic [4:0]    filt_cnt_q, filt_cnt_d;
    logic          filt_q, filt_d, filt_prev_q;
    logic          fall, bit_in, tmo_hit;

    rx_state_e     state_q;
    logic [7:0]    sr_q;
    logic [2:0]    bit_cnt_q;
    logic [1:0]    status_q;
    logic [TW-1:0] tmo_q;
    logic          busy_q;
    logic          overflow_q;

    logic                wr_en, drop;
    logic [ENTRY_W-1:0]  rd_entry;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_cnt_q  <= '0;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK_IN};
            data_sync_q <= {data_sync_q[0], PS2_DATA_IN};
            filt_cnt_q  <= filt_cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
        end
    end

    // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == 5'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
            else                                  filt_cnt_d = filt_cnt_q + 5'd1;
        end
    end

    assign fall    = filt_prev_q & ~filt_q;
    assign bit_in  = data_sync_q[1];
    assign tmo_hit = (tmo_q == TMO_MAX);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            status_q  <= '0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            if (fall)          tmo_q <= '0;
            else if (!tmo_hit) tmo_q <= tmo_q + 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (fall && !bit_in && RX_ENABLE) begin
                        state_q   <= ST_DATA;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        status_q  <= '0;
                        tmo_q     <= '0;
                    end
                end
                ST_DATA: begin
                    if (fall) begin
                        sr_q      <= {bit_in, sr_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7)
                            state_q <= (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
                    end else if (tmo_hit) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_PARITY: begin
                    if (fall) begin
                        status_q[ERR_PARITY] <= ((^sr_q) ^ bit_in) != (PARITY_MODE == PARITY_ODD);
                        state_q <= ST_STOP;
                    end else if (tmo_hit) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (fall) begin
                        status_q[ERR_STOP] <= ~bit_in;
                        state_q <= ST_PUSH;
                    end else if (tmo_hit) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_PUSH: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en = (state_q == ST_PUSH);

    ps2_byte_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .wr_en_i    (wr_en),
        .wr_data_i  ({status_q, sr_q}),
        .rd_en_i    (RD_EN),
        .rd_valid_o (RD_VALID),
        .rd_data_o  (rd_entry),
        .drop_o     (drop)
    );

    always_ff @(posedge CLK) begin
        if (RESET)             overflow_q <= 1'b0;
        else if (drop)         overflow_q <= 1'b1;
        else if (CLR_OVERFLOW) overflow_q <= 1'b0;
    end

    assign RD_DATA  = rd_entry[7:0];
    assign RD_ERR   = rd_entry[9:8];
    assign OVERFLOW = overflow_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_ps2_rx_buffered.sv
// Directed bench for ps2_rx_buffered: one odd-parity instance and one
// no-parity instance, driven bit by bit on a slow emulated PS/2 clock.
module tb_ps2_rx_buffered;

    localparam int H   = 10;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk = 1'b1, ps2_data = 1'b1;
    logic sel_b = 1'b0;
    logic rx_en = 1'b1;
    logic rd_en_a = 1'b0, rd_en_b = 1'b0;
    logic clr_ovf = 1'b0;

    logic       a_clk, a_data, b_clk, b_data;
    logic       valid_a, ovf_a, busy_a;
    logic [7:0] data_a;
    logic [1:0] err_a;
    logic       valid_b, ovf_b, busy_b;
    logic [7:0] data_b;
    logic [1:0] err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign a_clk  = sel_b ? 1'b1 : ps2_clk;
    assign a_data = sel_b ? 1'b1 : ps2_data;
    assign b_clk  = sel_b ? ps2_clk  : 1'b1;
    assign b_data = sel_b ? ps2_data : 1'b1;

    ps2_rx_buffered #(.TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4), .FILTER_LEN(4), .PARITY_MODE(0)) dut_a (
        .CLK(clk), .RESET(reset), .PS2_CLK_IN(a_clk), .PS2_DATA_IN(a_data), .RX_ENABLE(rx_en),
        .RD_EN(rd_en_a), .RD_VALID(valid_a), .RD_DATA(data_a), .RD_ERR(err_a),
        .OVERFLOW(ovf_a), .CLR_OVERFLOW(clr_ovf), .BUSY(busy_a));

    ps2_rx_buffered #(.TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4), .FILTER_LEN(4), .PARITY_MODE(2)) dut_b (
        .CLK(clk), .RESET(reset), .PS2_CLK_IN(b_clk), .PS2_DATA_IN(b_data), .RX_ENABLE(rx_en),
        .RD_EN(rd_en_b), .RD_VALID(valid_b), .RD_DATA(data_b), .RD_ERR(err_b),
        .OVERFLOW(ovf_b), .CLR_OVERFLOW(clr_ovf), .BUSY(busy_b));

    // One PS/2 bit: data set while the clock is high, then a low phase of H cycles.
    // pop_at pulses RD_EN on instance A for one cycle at that point of the low phase.
    task automatic send_bit(input logic v, input int pop_at);
        @(negedge clk); ps2_data = v;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        for (int i = 1; i <= H; i++) begin
            @(negedge clk);
            rd_en_a = (i == pop_at);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                              input logic has_par, input int pop_at);
        send_bit(1'b0, -1);
        for (int i = 0; i < 8; i++) send_bit(b[i], -1);
        if (has_par) send_bit(par, -1);
        send_bit(stp, pop_at);
        @(negedge clk); ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic pop_a();
        @(negedge clk); rd_en_a = 1'b1;
        @(negedge clk); rd_en_a = 1'b0;
    endtask

    task automatic pop_b();
        @(negedge clk); rd_en_b = 1'b1;
        @(negedge clk); rd_en_b = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_a); end
        checks++; if (err_a !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", err_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        // 0x5A has four ones, so the odd parity bit is 1
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, -1);
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL good_valid: got %b want 1", valid_a); end
        checks++; if (data_a !== 8'h5A) begin errors++; $display("FAIL good_data: got %h want 5a", data_a); end
        checks++; if (err_a !== 2'b00) begin errors++; $display("FAIL good_err: got %b want 00", err_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL good_busy: got %b want 0", busy_a); end
        pop_a();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL good_empty: got %b want 1'b0", valid_a); end
    endtask

    task automatic test_errors();
        logic [1:0] par_tab [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0] stp_tab [3] = '{1'b1, 1'b0, 1'b0};
        logic [1:0] exp_tab [3] = '{2'b01, 2'b10, 2'b11};
        for (int k = 0; k < 3; k++) begin
            send_frame(8'h5A, par_tab[k][0], stp_tab[k][0], 1'b1, -1);
            checks++; if (data_a !== 8'h5A) begin errors++; $display("FAIL err%0d_data: got %h want 5a", k, data_a); end
            checks++; if (err_a !== exp_tab[k]) begin errors++; $display("FAIL err%0d_status: got %b want %b", k, err_a, exp_tab[k]); end
            pop_a();
        end
    endtask

    task automatic test_rx_enable();
        rx_en = 1'b0;
        send_bit(1'b0, -1);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rxen_off_busy: got %b want 0", busy_a); end
        @(negedge clk); ps2_data = 1'b1;
        repeat (TMO + 10) @(negedge clk);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rxen_off_valid: got %b want 0", valid_a); end
        // drop enable right after the start bit: the frame must still complete
        rx_en = 1'b1;
        send_bit(1'b0, -1);
        rx_en = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(8'hC3 >> i, -1);
        send_bit(1'b1, -1);
        send_bit(1'b1, -1);
        @(negedge clk); ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        rx_en = 1'b1;
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL rxen_mid_valid: got %b want 1", valid_a); end
        checks++; if (data_a !== 8'hC3) begin errors++; $display("FAIL rxen_mid_data: got %h want c3", data_a); end
        checks++; if (err_a !== 2'b00) begin errors++; $display("FAIL rxen_mid_err: got %b want 00", err_a); end
        pop_a();
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send_frame(b, ~^b, 1'b1, 1'b1, -1);
        end
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf_a); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (data_a !== 8'(i) || valid_a !== 1'b1) begin errors++; $display("FAIL ovf_read%0d: got %h/%b want %h/1", i, data_a, valid_a, 8'(i)); end
            pop_a();
        end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", valid_a); end
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf_a); end
        // refill, then pop exactly in the cycle the fifth byte is pushed
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send_frame(b, ~^b, 1'b1, 1'b1, (i == 5) ? 7 : -1);
        end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_pushpop: got %b want 0", ovf_a); end
        for (int i = 2; i <= 5; i++) begin
            checks++; if (data_a !== 8'(i) || valid_a !== 1'b1) begin errors++; $display("FAIL ovf_keep%0d: got %h/%b want %h/1", i, data_a, valid_a, 8'(i)); end
            pop_a();
        end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL ovf_drain: got %b want 0", valid_a); end
    endtask

    task automatic test_timeout();
        send_bit(1'b0, -1);
        send_bit(1'b1, -1);
        send_bit(1'b0, -1);
        send_bit(1'b1, -1);
        send_bit(1'b0, -1);
        @(negedge clk); ps2_data = 1'b1;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL tmo_busy: got %b want 1", busy_a); end
        repeat (TMO + 16) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL tmo_idle: got %b want 0", busy_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL tmo_nopush: got %b want 0", valid_a); end
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, -1);
        checks++; if (data_a !== 8'hA5 || valid_a !== 1'b1) begin errors++; $display("FAIL tmo_next: got %h/%b want a5/1", data_a, valid_a); end
        checks++; if (err_a !== 2'b00) begin errors++; $display("FAIL tmo_next_err: got %b want 00", err_a); end
        pop_a();
    endtask

    task automatic test_glitch();
        logic seen_busy = 1'b0;
        @(negedge clk); ps2_data = 1'b0; ps2_clk = 1'b0;
        @(negedge clk);
        @(negedge clk); ps2_clk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (busy_a !== 1'b0) seen_busy = 1'b1;
        end
        ps2_data = 1'b1;
        checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", seen_busy); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", valid_a); end
    endtask

    task automatic test_no_parity();
        sel_b = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, -1);
        checks++; if (valid_b !== 1'b1) begin errors++; $display("FAIL np_valid: got %b want 1", valid_b); end
        checks++; if (data_b !== 8'h3C) begin errors++; $display("FAIL np_data: got %h want 3c", data_b); end
        checks++; if (err_b !== 2'b00) begin errors++; $display("FAIL np_err: got %b want 00", err_b); end
        pop_b();
        send_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, -1);
        checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL np_busy: got %b want 1", busy_b); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL np_reset_busy: got %b want 0", busy_b); end
        repeat (TMO + 16) @(negedge clk);
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL np_reset_nopush: got %b want 0", valid_b); end
        sel_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_errors();
        test_rx_enable();
        test_overflow();
        test_timeout();
        test_glitch();
        test_no_parity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_rx_buffered.md
PS2_RX_BUFFERED -- requirements
Module: ps2_rx_buffered

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000; CLK cycles allowed between falling edges inside a frame (1 ms at 100 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two and at least 2; received-byte buffer entries.
REQ-003 SHALL have parameter FILTER_LEN, default 4, range 1..16; consecutive equal samples needed before the filtered PS/2 clock changes level.
REQ-004 SHALL have parameter PARITY_MODE, default 0; 0 = odd, 1 = even, 2 = no parity bit (10-bit frame).
REQ-005 SHALL have port CLK, input, 1; system clock.
REQ-006 SHALL have port RESET, input, 1; synchronous, active-high reset.
REQ-007 SHALL have port PS2_CLK_IN, input, 1; asynchronous PS/2 clock line.
REQ-008 SHALL have port PS2_DATA_IN, input, 1; asynchronous PS/2 data line.
REQ-009 SHALL have port RX_ENABLE, input, 1; a start bit is accepted only while this is high.
REQ-010 SHALL have port RD_EN, input, 1; pops the head entry when RD_VALID is high.
REQ-011 SHALL have port RD_VALID, output, 1; buffer is not empty.
REQ-012 SHALL have port RD_DATA, output, 8; head byte, LSB received first.
REQ-013 SHALL have port RD_ERR, output, 2; head status, bit0 = parity error, bit1 = stop-bit error.
REQ-014 SHALL have port OVERFLOW, output, 1; sticky flag set when a byte was dropped.
REQ-015 SHALL have port CLR_OVERFLOW, input, 1; clears OVERFLOW.
REQ-016 SHALL have port BUSY, output, 1; high in every receive state other than IDLE.

Function
REQ-017 SHALL pass both PS/2 inputs through 2-flop synchronisers; the filtered clock SHALL take a new level only after FILTER_LEN consecutive equal synchronised samples.
REQ-018 SHALL define a falling edge as a filtered-clock 1->0 change, lasting one cycle; data SHALL be sampled from the synchronised data in that cycle.
REQ-019 SHALL use states IDLE, DATA, PARITY, STOP, PUSH.
REQ-020 In IDLE: falling edge with data 0 and RX_ENABLE high -> DATA; clear bit counter, status and timeout counter.
REQ-021 In DATA: each falling edge shifts the data bit into bit 7 of the shift register (right shift); after the 8th bit -> PARITY, or -> STOP when PARITY_MODE = 2.
REQ-022 In PARITY: on a falling edge, set status bit0 if (^byte ^ bit) is not 1 for odd mode, or not 0 for even mode; -> STOP.
REQ-023 In STOP: on a falling edge, set status bit1 if the bit is 0; -> PUSH.
REQ-024 In PUSH, one cycle: write {status, byte} into the buffer; -> IDLE. RD_VALID SHALL rise in the cycle after PUSH.
REQ-025 The timeout counter SHALL reset on every accepted falling edge and increment every cycle otherwise; reaching TIMEOUT_CYCLES in DATA, PARITY or STOP -> IDLE, and the partial frame is discarded without a push.
REQ-026 The buffer SHALL be show-ahead: RD_DATA/RD_ERR reflect the head whenever RD_VALID is high; RD_EN while empty is ignored.
REQ-027 A push while full with no pop in the same cycle SHALL drop the new byte and set OVERFLOW; a push and pop in the same cycle while full SHALL both succeed.
REQ-028 CLR_OVERFLOW SHALL clear OVERFLOW unless an overflow occurs in the same cycle, in which case the set wins.
REQ-029 Deasserting RX_ENABLE mid-frame SHALL NOT abort the current frame.
REQ-030 Read/write pointers SHALL be $clog2(FIFO_DEPTH) bits wide, wrap modulo FIFO_DEPTH, and use an extra occupancy bit or counter to distinguish full from empty.

Reset
REQ-031 RESET SHALL, at the next CLK edge: put the FSM in IDLE; clear the shift register, counters and status; empty the buffer (RD_VALID=0, RD_DATA=0, RD_ERR=0); set OVERFLOW=0 and BUSY=0; and load all filter and synchroniser flops with 1 (idle bus).
REQ-032 RESET asserted mid-frame SHALL discard the frame; no push SHALL occur.

Structure
REQ-033 A shared package ps2_pkg SHALL hold the state encoding, parity-mode constants and RD_ERR bit indices.
REQ-034 The buffer SHALL be a separate sub-module, ps2_byte_fifo, parametrised by width (10) and FIFO_DEPTH.

Verification
REQ-035 Byte 0x5A with odd parity bit 1 and stop 1 -> RD_VALID, RD_DATA=0x5A, RD_ERR=00.
REQ-036 Byte 0x5A with parity bit 0 -> RD_ERR=01; stop bit 0 -> RD_ERR=10; both -> 11.
REQ-037 Five frames 0x01..0x05 with no reads (FIFO_DEPTH=4) -> 0x01..0x04 buffered, OVERFLOW=1; CLR_OVERFLOW -> 0; RD_EN at the 5th push -> 0x05 retained.
REQ-038 PS/2 clock stops after the 4th data bit -> back to IDLE after TIMEOUT_CYCLES with no push; next full frame 0xA5 is received correctly.
REQ-039 A 2-cycle low glitch on PS2_CLK_IN with FILTER_LEN=4 -> no edge detected, BUSY stays 0.
REQ-040 PARITY_MODE=2 frame 0x3C -> pushed after the stop bit with RD_ERR=00; RESET after the 5th bit -> no push and BUSY=0.
